// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-add step per clock through a single
// carry register, with a start/ready/busy/done handshake.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] ps;
  logic             c;
  logic [KW-1:0]    k;

  logic             bit_s;
  logic             carry_nxt;
  logic [WIDTH-1:0] ps_nxt;

  // One-bit add cell: two half-adders plus OR for the carry.
  always_comb begin
    bit_s     = sa[0] ^ sb[0] ^ c;
    carry_nxt = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
    ps_nxt    = ps >> 1;
    ps_nxt[WIDTH-1] = bit_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sa    <= '0;
      sb    <= '0;
      ps    <= '0;
      c     <= 1'b0;
      k     <= '0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            ps    <= '0;
            c     <= 1'b0;
            k     <= '0;
            state <= S_RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          c  <= carry_nxt;
          ps <= ps_nxt;
          sa <= sa >> 1;
          sb <= sb >> 1;
          k  <= k + KW'(1);
          // Final bit: publish the result on the same edge that leaves RUN.
          if (k == KW'(WIDTH - 1)) begin
            state <= S_DONE;
            sum   <= ps_nxt;
            cout  <= carry_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
